mul_trace_writer: RTL and testbench

- Bus-side stimulus generator that drives the CPU data-memory write interface into the test-port checker, in place of a CPU core.
- Emits a framed result stream to TEST_PORT: begin symbol, operands A and B, the 16 partial products of a 16x16 shift-add multiply, then the end symbol.
- Drives data little-endian on the bus.
- Used to validate the checker/TestBed path and stall handling independently of the pipeline.

---
 rtl/mul_trace_writer.sv | 122 ++++++++++++
 tb/tb_mul_trace_writer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_trace_writer.sv
// Stands in for a CPU core on the data-memory write bus: emits one framed trace of a
// 16x16 shift-add multiply (begin, A, B, 16 partial products, end) to the test port.
module mul_trace_writer #(
    parameter logic [29:0] TEST_PORT  = 30'h10,
    parameter logic [31:0] BEGIN_SYM  = 32'h00000168,
    parameter logic [31:0] END_SYM    = 32'hFFFFFD5D,
    parameter int          GAP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    input  logic        stall,
    output logic [29:0] addr,
    output logic [31:0] data,
    output logic        wen,
    output logic        busy,
    output logic        done,
    output logic [4:0]  wr_count
);

    typedef enum logic [1:0] {IDLE, WRITE, GAP, DONE} state_t;

    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

    state_t      state;
    logic [15:0] a_reg;
    logic [15:0] b_reg;
    logic [31:0] r_reg;
    logic [4:0]  idx;
    logic [3:0]  gap_cnt;

    logic [4:0]  idx_inc;
    logic [3:0]  bit_sel;
    logic [32:0] r_sum;
    logic [31:0] r_next;
    logic [31:0] next_word;

    function automatic logic [31:0] swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Completing write idx (2..17) folds in multiplier bit idx-2; the 33-bit sum keeps the carry.
    always_comb begin
        idx_inc = idx + 5'd1;
        bit_sel = idx[3:0] - 4'd2;
        r_sum   = {1'b0, r_reg} + (b_reg[bit_sel] ? {1'b0, a_reg, 16'h0000} : 33'd0);
        r_next  = r_sum[32:1];
        case (idx_inc)
            5'd1:    next_word = {16'h0000, a_reg};
            5'd2:    next_word = {16'h0000, b_reg};
            5'd19:   next_word = END_SYM;
            5'd0:    next_word = BEGIN_SYM;
            default: next_word = r_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            r_reg    <= '0;
            idx      <= '0;
            gap_cnt  <= '0;
            addr     <= '0;
            data     <= '0;
            wen      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_count <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= WRITE;
                        a_reg    <= op_a;
                        b_reg    <= op_b;
                        r_reg    <= '0;
                        idx      <= '0;
                        addr     <= TEST_PORT;
                        data     <= swap(BEGIN_SYM);
                        wen      <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        wr_count <= '0;
                    end
                end
                WRITE: begin
                    if (!stall) begin
                        wen <= 1'b0;
                        if (wr_count != 5'd20)
                            wr_count <= wr_count + 5'd1;
                        if (idx >= 5'd2 && idx <= 5'd17)
                            r_reg <= r_next;
                        if (idx < 5'd19) begin
                            state   <= GAP;
                            gap_cnt <= GAP_LOAD;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == 4'd0) begin
                        state <= WRITE;
                        idx   <= idx_inc;
                        data  <= swap(next_word);
                        wen   <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_trace_writer.sv
// Directed bench for mul_trace_writer: nominal, stall, carry, zero-operand, spurious start,
// mid-frame reset and a wider-gap instance, with hand-computed expectations.
module tb_mul_trace_writer;

    logic        clk = 1'b0;
    logic        rst, start, stall;
    logic [15:0] op_a, op_b;
    logic [29:0] addr;
    logic [31:0] data;
    logic        wen, busy, done;
    logic [4:0]  wr_count;

    logic        start3, stall3;
    logic [29:0] addr3;
    logic [31:0] data3;
    logic        wen3, busy3, done3;
    logic [4:0]  wr_count3;

    int compared = 0;
    int mismatched = 0;

    logic [31:0] bus_q[$];
    logic [29:0] addr_q[$];
    int          hi_len[$];
    int          gap_q[$];
    int          hold_err = 0;
    int          low_cnt = 0;
    logic        wen_q = 1'b0;
    logic [31:0] held_data;
    logic [29:0] held_addr;

    int   gap3_q[$];
    int   writes3 = 0;
    int   low3 = 0;
    logic wen3_q = 1'b0;

    mul_trace_writer dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .stall(stall),
        .addr(addr), .data(data), .wen(wen), .busy(busy), .done(done), .wr_count(wr_count)
    );

    mul_trace_writer #(.GAP_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .op_a(op_a), .op_b(op_b), .stall(stall3),
        .addr(addr3), .data(data3), .wen(wen3), .busy(busy3), .done(done3), .wr_count(wr_count3)
    );

    always #5 clk = ~clk;

    // Bus monitor: one entry per wen-high period, plus its length and the preceding gap.
    always @(posedge clk) begin
        #1;
        if (wen === 1'b1) begin
            if (wen_q !== 1'b1) begin
                if (bus_q.size() > 0) gap_q.push_back(low_cnt);
                bus_q.push_back(data);
                addr_q.push_back(addr);
                hi_len.push_back(1);
                held_data = data;
                held_addr = addr;
            end else if (hi_len.size() > 0) begin
                hi_len[hi_len.size()-1] = hi_len[hi_len.size()-1] + 1;
                if (data !== held_data || addr !== held_addr) hold_err++;
            end
            low_cnt = 0;
        end else begin
            low_cnt++;
        end
        wen_q = wen;
        if (wen3 === 1'b1) begin
            if (wen3_q !== 1'b1) begin
                if (writes3 > 0) gap3_q.push_back(low3);
                writes3++;
            end
            low3 = 0;
        end else begin
            low3++;
        end
        wen3_q = wen3;
    end

    function automatic logic [31:0] swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [31:0] expWord(input int i, input logic [15:0] a, input logic [15:0] b);
        logic [32:0] s;
        logic [31:0] r;
        if (i == 0) return 32'h00000168;
        if (i == 1) return {16'h0000, a};
        if (i == 2) return {16'h0000, b};
        if (i == 19) return 32'hFFFFFD5D;
        r = 32'h0;
        for (int k = 1; k <= i - 2; k++) begin
            s = {1'b0, r} + (b[k-1] ? {1'b0, a, 16'h0000} : 33'd0);
            r = s[32:1];
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clearCapture();
        bus_q.delete();
        addr_q.delete();
        hi_len.delete();
        gap_q.delete();
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("first_wen", 32'(wen), 32'd1);
        checkOutput("first_busy", 32'(busy), 32'd1);
        checkOutput("count_cleared", 32'(wr_count), 32'd0);
    endtask

    task automatic waitWrites(input int n, input string tag);
        int c = 0;
        while (bus_q.size() < n && c < 500) begin
            @(negedge clk);
            c++;
        end
        checkOutput(tag, (bus_q.size() >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic waitDone(input string tag);
        int c = 0;
        while (done !== 1'b1 && c < 1000) begin
            @(negedge clk);
            c++;
        end
        checkOutput(tag, 32'(done), 32'd1);
    endtask

    task automatic checkFrame(input logic [15:0] a, input logic [15:0] b, input string name,
                              input int stall_idx);
        int bad_addr = 0;
        int bad_gap = 0;
        int bad_len = 0;
        checkOutput({name, "_writes"}, 32'(bus_q.size()), 32'd20);
        for (int i = 0; i < 20 && i < bus_q.size(); i++) begin
            checkOutput($sformatf("%s_w%0d", name, i), swap(bus_q[i]), expWord(i, a, b));
            if (addr_q[i] !== 30'h10) bad_addr++;
            if (hi_len[i] != ((i == stall_idx) ? 6 : 1)) bad_len++;
        end
        foreach (gap_q[i]) if (gap_q[i] != 1) bad_gap++;
        checkOutput({name, "_bad_addr"}, 32'(bad_addr), 32'd0);
        checkOutput({name, "_bad_wen_len"}, 32'(bad_len), 32'd0);
        checkOutput({name, "_gaps"}, 32'(gap_q.size()), 32'd19);
        checkOutput({name, "_bad_gap"}, 32'(bad_gap), 32'd0);
        if (bus_q.size() >= 19)
            checkOutput({name, "_product"}, swap(bus_q[18]), 32'(a) * 32'(b));
        checkOutput({name, "_done"}, 32'(done), 32'd1);
        checkOutput({name, "_busy"}, 32'(busy), 32'd0);
        checkOutput({name, "_wr_count"}, 32'(wr_count), 32'd20);
    endtask

    initial begin
        int bad3;
        rst    = 1'b1;
        start  = 1'b0;
        stall  = 1'b0;
        start3 = 1'b0;
        stall3 = 1'b0;
        op_a   = '0;
        op_b   = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_wen", 32'(wen), 32'd0);
        checkOutput("rst_addr", 32'(addr), 32'd0);
        checkOutput("rst_data", data, 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_count", 32'(wr_count), 32'd0);
        rst = 1'b0;

        // Nominal frame with a 5-cycle stall on the write carrying 0x03B29000 (idx 8).
        clearCapture();
        applyStimulus(16'h1234, 16'hABCD);
        waitWrites(9, "reach_idx8");
        stall = 1'b1;
        checkOutput("stall_count_before", 32'(wr_count), 32'd8);
        repeat (5) @(negedge clk);
        checkOutput("stall_wen_held", 32'(wen), 32'd1);
        checkOutput("stall_count_held", 32'(wr_count), 32'd8);
        checkOutput("stall_data_held", swap(data), 32'h03B29000);
        stall = 1'b0;
        waitDone("nom_done_wait");
        checkFrame(16'h1234, 16'hABCD, "nom", 8);
        if (bus_q.size() >= 20) begin
            checkOutput("nom_bus0", bus_q[0], 32'h68010000);
            checkOutput("nom_bus1", bus_q[1], 32'h34120000);
            checkOutput("nom_bus2", bus_q[2], 32'hCDAB0000);
            checkOutput("nom_r1", swap(bus_q[3]), 32'h091A0000);
            checkOutput("nom_r2", swap(bus_q[4]), 32'h048D0000);
            checkOutput("nom_r3", swap(bus_q[5]), 32'h0B608000);
            checkOutput("nom_r16", swap(bus_q[18]), 32'h0C374FA4);
            checkOutput("nom_bus19", bus_q[19], 32'h5DFDFFFF);
        end

        // Carry path, started straight from DONE.
        clearCapture();
        applyStimulus(16'hFFFF, 16'hFFFF);
        waitDone("carry_done_wait");
        checkFrame(16'hFFFF, 16'hFFFF, "carry", -1);
        if (bus_q.size() >= 20) begin
            checkOutput("carry_r2", swap(bus_q[4]), 32'hBFFF4000);
            checkOutput("carry_final", swap(bus_q[18]), 32'hFFFE0001);
        end

        // Zero multiplicand: every partial product is zero.
        clearCapture();
        applyStimulus(16'h0000, 16'hABCD);
        waitDone("zero_done_wait");
        checkFrame(16'h0000, 16'hABCD, "zero", -1);
        if (bus_q.size() >= 20) begin
            checkOutput("zero_bus0", bus_q[0], 32'h68010000);
            checkOutput("zero_r8", swap(bus_q[10]), 32'h00000000);
            checkOutput("zero_end", swap(bus_q[19]), 32'hFFFFFD5D);
        end

        // Spurious starts during WRITE and GAP.
        clearCapture();
        applyStimulus(16'h1234, 16'hABCD);
        waitWrites(3, "reach_idx2");
        start = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone("spur_done_wait");
        checkFrame(16'h1234, 16'hABCD, "spur", -1);

        // Wider gap on the second instance.
        @(negedge clk);
        op_a   = 16'h1234;
        op_b   = 16'hABCD;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        begin
            int c = 0;
            while (done3 !== 1'b1 && c < 1000) begin
                @(negedge clk);
                c++;
            end
        end
        checkOutput("gap3_done", 32'(done3), 32'd1);
        checkOutput("gap3_writes", 32'(writes3), 32'd20);
        checkOutput("gap3_count", 32'(wr_count3), 32'd20);
        checkOutput("gap3_gaps", 32'(gap3_q.size()), 32'd19);
        bad3 = 0;
        foreach (gap3_q[i]) if (gap3_q[i] != 3) bad3++;
        checkOutput("gap3_bad_gap", 32'(bad3), 32'd0);

        // Reset in the middle of write idx 10, then a clean frame.
        clearCapture();
        applyStimulus(16'h1234, 16'hABCD);
        waitWrites(11, "reach_idx10");
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_wen", 32'(wen), 32'd0);
        checkOutput("midrst_count", 32'(wr_count), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_data", data, 32'd0);
        rst = 1'b0;
        clearCapture();
        applyStimulus(16'h1234, 16'hABCD);
        waitDone("after_rst_done_wait");
        checkFrame(16'h1234, 16'hABCD, "after_rst", -1);

        checkOutput("hold_errors", 32'(hold_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
